// File: rtl/pipe_ctrl.sv
// Pipeline hazard / multi-cycle / redirect controller.
//
// Combines decode and execute stall requests, multi-cycle execute
// operations and flush/redirect requests into per-stage hold signals,
// a registered flush pulse with its redirect target, and a stall-cycle
// counter.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   stallreq_id   decode-stage operand-hazard stall request
//   stallreq_ex   execute-stage single-cycle stall request
//   mc_start      execute issues a multi-cycle operation
//   mc_cycles     length N of that operation (sampled with mc_start)
//   flush_req     exception / redirect request
//   flush_pc      redirect target (sampled with flush_req)
//   stall[5:0]    per-stage hold: pc, if/id, id/ex, ex/mem, mem/wb, wb
//   flush         registered one-cycle flush pulse
//   new_pc        registered redirect address, valid while flush=1
//   mc_done       multi-cycle result valid in EX this cycle
//   busy          controller not idle
//   stall_cycles  saturating count of cycles with any stall bit set
//
// state | meaning
// IDLE  | no operation in flight; plain stall requests are passed through
// MULTI | multi-cycle operation running; cnt counts down to the done cycle
// FLUSH | one-cycle flush pulse with new_pc on the pipeline registers

module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        mc_start,
   input  logic [5:0]  mc_cycles,
   input  logic        flush_req,
   input  logic [31:0] flush_pc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        mc_done,
   output logic        busy,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MULTI = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_ID = 6'b000111;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        flush_q;
   logic [5:0]  req_stall;

   assign req_stall = stallreq_ex ? STALL_EX :
                      stallreq_id ? STALL_ID : 6'b000000;

   // A flush request outranks every stall source: the pipeline is about to
   // be emptied, so nothing is held in the request cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 6'b000000;
      mc_done = 1'b0;
      if (rst) begin
         state_d = IDLE;
         cnt_d   = 6'd0;
      end else if (flush_req) begin
         state_d = FLUSH;
         cnt_d   = 6'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mc_start) begin
                  stall   = STALL_EX;
                  // N=0 is treated as a one-cycle operation
                  cnt_d   = (mc_cycles == 6'd0) ? 6'd1 : mc_cycles;
                  state_d = MULTI;
               end else begin
                  stall = req_stall;
               end
            end
            MULTI: begin
               if (cnt_q > 6'd1) begin
                  stall = STALL_EX;
                  cnt_d = cnt_q - 6'd1;
               end else begin
                  mc_done = 1'b1;
                  stall   = req_stall;
                  cnt_d   = 6'd0;
                  state_d = IDLE;
               end
            end
            FLUSH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 6'd0;
            end
         endcase
      end
   end

   assign flush = flush_q & ~rst;
   assign busy  = (state_q != IDLE) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 6'd0;
         flush_q      <= 1'b0;
         new_pc       <= 32'h0000_0000;
         stall_cycles <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_req;
         if (flush_req) begin
            new_pc <= flush_pc;
         end
         if ((stall != 6'b000000) && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.

module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        mc_start;
   logic [5:0]  mc_cycles;
   logic        flush_req;
   logic [31:0] flush_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_done;
   logic        busy;
   logic [31:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // reference model: operation in flight, stall cycles still owed before
   // the done cycle, flush pulse pending, redirect target, stall count
   bit          m_in_mc   = 1'b0;
   int          m_left    = 0;
   bit          m_flushing = 1'b0;
   logic [31:0] m_pc      = 32'h0;
   logic [31:0] m_count   = 32'h0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .mc_start     (mc_start),
      .mc_cycles    (mc_cycles),
      .flush_req    (flush_req),
      .flush_pc     (flush_pc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .mc_done      (mc_done),
      .busy         (busy),
      .stall_cycles (stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, compare all
   // outputs against the model, then advance the model to the next edge.
   task automatic cycle(input bit r, input bit id, input bit ex, input bit ms,
                        input logic [5:0] n, input bit fr, input logic [31:0] fpc);
      logic [5:0] e_stall;
      logic [5:0] e_req;
      bit         e_done;
      bit         e_flush;
      bit         e_busy;
      @(negedge clk);
      rst = r; stallreq_id = id; stallreq_ex = ex; mc_start = ms;
      mc_cycles = n; flush_req = fr; flush_pc = fpc;
      #1;
      e_req   = ex ? 6'b001111 : (id ? 6'b000111 : 6'b000000);
      e_stall = 6'b000000;
      e_done  = 1'b0;
      e_flush = !r && m_flushing;
      e_busy  = !r && (m_in_mc || m_flushing);
      if (r || fr) begin
         e_stall = 6'b000000;
      end else if (m_in_mc && m_left > 0) begin
         e_stall = 6'b001111;
      end else if (m_in_mc) begin
         e_done  = 1'b1;
         e_stall = e_req;
      end else if (m_flushing) begin
         e_stall = 6'b000000;
      end else if (ms) begin
         e_stall = 6'b001111;
      end else begin
         e_stall = e_req;
      end
      if (chk_en) begin
         chk("stall", {26'd0, stall}, {26'd0, e_stall});
         chk("flush", {31'd0, flush}, {31'd0, e_flush});
         chk("mc_done", {31'd0, mc_done}, {31'd0, e_done});
         chk("busy", {31'd0, busy}, {31'd0, e_busy});
         chk("stall_cycles", stall_cycles, m_count);
         if (e_flush) chk("new_pc", new_pc, m_pc);
      end
      if (r) begin
         m_in_mc = 0; m_left = 0; m_flushing = 0; m_pc = 32'h0; m_count = 32'h0;
      end else begin
         if (e_stall != 6'b000000 && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
         if (fr) begin
            m_flushing = 1; m_pc = fpc; m_in_mc = 0; m_left = 0;
         end else if (m_in_mc && m_left > 0) begin
            m_left = m_left - 1;
         end else if (m_in_mc) begin
            m_in_mc = 0;
         end else if (m_flushing) begin
            m_flushing = 0;
         end else if (ms) begin
            m_in_mc = 1;
            m_left  = ((n == 6'd0) ? 1 : int'(n)) - 1;
         end
      end
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 6'd0, 0, 32'h0);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 6'd0, 0, 32'h0);
      cycle(1, 1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
   endtask

   initial begin
      rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; mc_start = 0;
      mc_cycles = 0; flush_req = 0; flush_pc = 0;
      cycle(1, 0, 0, 0, 6'd0, 0, 32'h0);
      chk_en = 1'b1;
      do_reset();
      idle(1);
      chk("reset_new_pc", new_pc, 32'h0);

      // decode stall for three cycles
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 6'd0, 0, 32'h0);
      idle(1);
      chk("id3_count", stall_cycles, 32'd3);

      // four-cycle operation
      cycle(0, 0, 0, 1, 6'd4, 0, 32'h0);
      idle(6);
      chk("mc4_count", stall_cycles, 32'd7);

      // zero-length operation, with start ignored while busy
      cycle(0, 0, 0, 1, 6'd0, 0, 32'h0);
      cycle(0, 0, 0, 1, 6'd9, 0, 32'h0);
      idle(2);

      // done cycle still honours execute / decode requests
      cycle(0, 0, 0, 1, 6'd2, 0, 32'h0);
      cycle(0, 1, 0, 0, 6'd0, 0, 32'h0);
      cycle(0, 1, 1, 0, 6'd0, 0, 32'h0);
      cycle(0, 0, 0, 1, 6'd1, 0, 32'h0);
      cycle(0, 1, 0, 0, 6'd0, 0, 32'h0);
      idle(1);

      // redirect aborts an eight-cycle operation at T3
      cycle(0, 0, 0, 1, 6'd8, 0, 32'h0);
      idle(2);
      cycle(0, 0, 0, 0, 6'd0, 1, 32'hBFC0_0380);
      idle(1);
      chk("abort_new_pc", new_pc, 32'hBFC0_0380);
      idle(3);

      // both stall requests, then flush beating them, then back-to-back flush
      cycle(0, 1, 1, 0, 6'd0, 0, 32'h0);
      cycle(0, 1, 1, 1, 6'd3, 1, 32'h0000_1000);
      cycle(0, 1, 1, 0, 6'd0, 1, 32'h0000_2000);
      idle(1);
      chk("flush2_new_pc", new_pc, 32'h0000_2000);
      idle(1);

      // reset while cnt=5 in an eight-cycle operation
      cycle(0, 0, 0, 1, 6'd8, 0, 32'h0);
      idle(3);
      cycle(1, 1, 1, 1, 6'd3, 1, 32'h1234_5678);
      idle(10);
      chk("rst_mid_count", stall_cycles, 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 100) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0,
               ($urandom % 6) == 0, 6'($urandom % 11), ($urandom % 25) == 0,
               $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
